sv_unloader: RTL

SV_UNLOADER -- requirements
Module: sv_unloader

---
 rtl/qcm_sv_pkg.sv | 24 ++
 rtl/sv_unloader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/qcm_sv_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the
// state-vector unloader.
package qcm_sv_pkg;

  localparam int SAMPLE_SIZE    = 32;
  localparam int COMPLEXNUM_BIT = 24;
  localparam int OUT_BIT        = 32;
  localparam int IDX_W          = $clog2(SAMPLE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Replicates bit width-1 of value into all higher bits (1 <= width <= 64).
  function automatic logic [63:0] sign_extend(input logic [63:0] value,
                                              input int unsigned width);
    logic signed [63:0] v_shl;
    v_shl = signed'(value << (32'd64 - width));
    return $unsigned(v_shl >>> (32'd64 - width));
  endfunction

endpackage

// File: rtl/sv_unloader.sv
// Snapshots a parallel state vector on start and streams it out one complex
// amplitude per valid/ready handshake, sign-extended to out_bit.
module sv_unloader
  import qcm_sv_pkg::*;
#(
  parameter int sample_size    = SAMPLE_SIZE,
  parameter int complexnum_bit = COMPLEXNUM_BIT,
  parameter int out_bit        = OUT_BIT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic signed [complexnum_bit-1:0] in_r [0:sample_size-1],
  input  logic signed [complexnum_bit-1:0] in_i [0:sample_size-1],
  output logic                             busy,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [$clog2(sample_size)-1:0]   o_idx,
  output logic signed [out_bit-1:0]        o_r,
  output logic signed [out_bit-1:0]        o_i,
  output logic                             o_last,
  output logic                             done
);

  localparam int IW = $clog2(sample_size);
  localparam logic [IW-1:0] LAST_IDX = IW'(sample_size - 1);

  state_t r_state;
  state_t w_next_state;
  logic [IW-1:0] r_idx;
  logic signed [complexnum_bit-1:0] r_snap_r [0:sample_size-1];
  logic signed [complexnum_bit-1:0] r_snap_i [0:sample_size-1];
  logic w_load;
  logic w_xfer;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/status outputs; o_valid never looks at o_ready.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_xfer       = 1'b0;
    busy         = 1'b0;
    o_valid      = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_STREAM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STREAM: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        w_xfer  = o_ready;
        if (o_ready && (r_idx == LAST_IDX)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Snapshot capture and streaming index; the index parks on the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= {IW{1'b0}};
      for (int k = 0; k < sample_size; k++) begin
        r_snap_r[k] <= {complexnum_bit{1'b0}};
        r_snap_i[k] <= {complexnum_bit{1'b0}};
      end
    end else if (w_load) begin
      r_idx <= {IW{1'b0}};
      for (int k = 0; k < sample_size; k++) begin
        r_snap_r[k] <= in_r[k];
        r_snap_i[k] <= in_i[k];
      end
    end else if (w_xfer && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + IW'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Data mux; outputs read as zero whenever no word is being offered.
  always_comb begin
    o_idx  = {IW{1'b0}};
    o_r    = {out_bit{1'b0}};
    o_i    = {out_bit{1'b0}};
    o_last = 1'b0;
    if (r_state == ST_STREAM) begin
      o_idx  = r_idx;
      o_r    = out_bit'(sign_extend(64'($unsigned(r_snap_r[r_idx])),
                                    unsigned'(complexnum_bit)));
      o_i    = out_bit'(sign_extend(64'($unsigned(r_snap_i[r_idx])),
                                    unsigned'(complexnum_bit)));
      o_last = (r_idx == LAST_IDX);
    end else begin
      o_last = 1'b0;
    end
  end

endmodule
